thr_table_loader: RTL and testbench
===================================

Name: thr_table_loader

Overview:
- Configuration controller for the comparator threshold BRAM inside the Tanimoto datapath.
- Accepts threshold entries on a valid/ready config stream and writes them to BRAM addresses 0..VECTOR_WIDTH in order, one entry per popcount value.
- Gates the vector input stream so that no vector enters the datapath until a complete table is loaded.
- Sits between the host-side config stream / S_AXIS_DATA handshake and the datapath BRAM port and i_Valid/o_Read.

Parameters:
- VECTOR_WIDTH, 920: fingerprint width in bits; the table holds DEPTH = VECTOR_WIDTH+1 entries.
- CNT_WIDTH, $clog2(VECTOR_WIDTH+1): width of BRAM address and data.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- i_Start  in  1  single-cycle pulse that begins a table load.
- i_Cfg_Data  in  CNT_WIDTH  threshold entry.
- i_Cfg_Valid  in  1  i_Cfg_Data is valid.
- o_Cfg_Ready  out  1  loader accepts an entry this cycle.
- o_BRAM_Addr  out  CNT_WIDTH  write address.
- o_BRAM_Din  out  CNT_WIDTH  write data.
- o_BRAM_En  out  1  BRAM enable.
- o_BRAM_WrEn  out  1  BRAM write enable.
- o_Busy  out  1  a load is in progress.
- o_Table_Valid  out  1  a complete table is resident.
- o_Entry_Cnt  out  CNT_WIDTH+1  number of entries written in the current load.
- o_Cfg_Err  out  1  sticky monotonicity error (see Optional Feature).
- i_Vec_Valid  in  1  upstream vector valid (S_AXIS_DATA_tvalid).
- o_Vec_Valid  out  1  gated valid to the datapath i_Valid.
- i_Vec_Read  in  1  datapath o_Read.
- o_Vec_Ready  out  1  gated ready to upstream (S_AXIS_DATA_tready).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; address counter 0; o_Table_Valid 0.
- States:
  - IDLE: waits for i_Start.
  - LOAD: accepts and writes entries.
  - DONE: table resident.
- Transitions:
  - IDLE --i_Start--> LOAD.
  - LOAD --last entry accepted--> DONE.
  - DONE --i_Start--> LOAD.
- Entering LOAD: clear the counter, o_Entry_Cnt and o_Table_Valid; set o_Busy.
- o_Cfg_Ready: combinational, equal to (state==LOAD).
- Accept: i_Cfg_Valid & o_Cfg_Ready.
- Write latency: an entry accepted in cycle n is written in cycle n+1.
  - o_BRAM_En = o_BRAM_WrEn = 1 for exactly that cycle.
  - o_BRAM_Addr = counter value at accept; o_BRAM_Din = the accepted data.
  - Address and data hold their last value when En = 0.
- After each accept, the counter and o_Entry_Cnt increment.
- Last entry is the accept at counter == VECTOR_WIDTH:
  - next cycle: state DONE, o_Busy = 0, o_Table_Valid = 1;
  - o_Cfg_Ready is already 0 in that cycle; the counter never wraps.
- i_Start in LOAD is ignored; the load continues.
- i_Start in DONE:
  - o_Table_Valid drops the next cycle and a new load starts;
  - vector gating closes immediately from that cycle.
- i_Cfg_Valid outside LOAD is ignored and not acknowledged.
- Vector gating (combinational):
  - o_Vec_Valid = i_Vec_Valid & o_Table_Valid;
  - o_Vec_Ready = i_Vec_Read & o_Table_Valid.
- Reset mid-load: the partial table is abandoned, o_Table_Valid = 0, and no BRAM write is issued in the reset cycle or the cycle after it.
- Simultaneous rst and i_Start: reset wins.

Optional Feature:
- Macro THR_MONO_CHECK_EN.
- Defined:
  - Each accepted entry is compared with the previously accepted entry of the same load.
  - If the entry is smaller, o_Cfg_Err sets (sticky until the next i_Start or rst). The write still occurs.
  - At end of load with o_Cfg_Err = 1: state goes to IDLE (not DONE) and o_Table_Valid stays 0.
- Not defined: o_Cfg_Err is tied to 0, no comparator is built, and every completed load goes to DONE.

Test Plan:
- Reset then load (VECTOR_WIDTH=7, DEPTH=8):
  - Stimulus: rst, i_Start, 8 entries 0,1,1,2,3,3,4,5 sent back-to-back.
  - Required: writes at addresses 0..7 with matching data, each one cycle after its accept; o_Table_Valid=1 one cycle after the 8th accept; o_Entry_Cnt=8; o_Cfg_Ready=0 after that.
- Backpressure gaps:
  - Stimulus: i_Cfg_Valid toggling 1,0,0,1,...
  - Required: the write sequence is still exactly addresses 0..7 with no duplicates; o_Busy=1 throughout.
- Vector gating:
  - Stimulus: i_Vec_Valid=1 and i_Vec_Read=1 before the load completes.
  - Required: o_Vec_Valid=0 and o_Vec_Ready=0 until o_Table_Valid=1, then both pass through.
- Reload from DONE:
  - Stimulus: i_Start pulse while vectors are flowing.
  - Required: gating closes the next cycle; o_Entry_Cnt=0; the new table writes from address 0.
- Reset mid-load:
  - Stimulus: rst after 3 entries.
  - Required: all outputs return to 0, no BRAM write, state IDLE; a subsequent i_Start reloads from address 0.
- THR_MONO_CHECK_EN defined:
  - Stimulus: entries 0,2,1,3,4,5,6,7.
  - Required: o_Cfg_Err=1 one cycle after the 3rd accept; all 8 writes issued; end state IDLE with o_Table_Valid=0.
  - Without the macro: same stimulus gives o_Table_Valid=1 and o_Cfg_Err=0.

Source files
------------

// File: rtl/thr_table_loader.sv
// Loads the comparator threshold BRAM from a valid/ready config stream and gates the
// vector stream until a complete table is resident. Optional build macro: THR_MONO_CHECK_EN.
module thr_table_loader #(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Start,
    input  logic [CNT_WIDTH-1:0] i_Cfg_Data,
    input  logic                 i_Cfg_Valid,
    output logic                 o_Cfg_Ready,
    output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
    output logic [CNT_WIDTH-1:0] o_BRAM_Din,
    output logic                 o_BRAM_En,
    output logic                 o_BRAM_WrEn,
    output logic                 o_Busy,
    output logic                 o_Table_Valid,
    output logic [CNT_WIDTH:0]   o_Entry_Cnt,
    output logic                 o_Cfg_Err,
    input  logic                 i_Vec_Valid,
    output logic                 o_Vec_Valid,
    input  logic                 i_Vec_Read,
    output logic                 o_Vec_Ready
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ADDR_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   ENTRY_ONE = (CNT_WIDTH + 1)'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [CNT_WIDTH:0]   entry_cnt_q, entry_cnt_d;
    logic [CNT_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [CNT_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                 bram_en_q, bram_en_d;
    logic                 busy_q, busy_d;
    logic                 table_valid_q, table_valid_d;
    logic                 err_d;

    logic accept, start_load, last_accept;
    assign accept      = i_Cfg_Valid & (state_q == LOAD);
    assign start_load  = i_Start & (state_q != LOAD);
    assign last_accept = accept & (addr_cnt_q == LAST_ADDR);

`ifdef THR_MONO_CHECK_EN
    logic [CNT_WIDTH-1:0] prev_q, prev_d;
    logic                 err_q;

    // prev is cleared on load start, so the first entry can never flag a descent.
    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (start_load) begin
            prev_d = '0;
            err_d  = 1'b0;
        end else if (accept) begin
            prev_d = i_Cfg_Data;
            if (i_Cfg_Data < prev_q) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign o_Cfg_Err = err_q;
`else
    assign err_d     = 1'b0;
    assign o_Cfg_Err = 1'b0;
`endif

    // NOTE: every _d gets a hold/default value first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        entry_cnt_d   = entry_cnt_q;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        bram_en_d     = 1'b0;
        busy_d        = busy_q;
        table_valid_d = table_valid_q;

        if (start_load) begin
            state_d       = LOAD;
            addr_cnt_d    = '0;
            entry_cnt_d   = '0;
            busy_d        = 1'b1;
            table_valid_d = 1'b0;
        end else if (accept) begin
            bram_en_d   = 1'b1;
            bram_addr_d = addr_cnt_q;
            bram_din_d  = i_Cfg_Data;
            entry_cnt_d = entry_cnt_q + ENTRY_ONE;
            // The address counter saturates on the last entry instead of wrapping.
            if (last_accept) begin
                busy_d        = 1'b0;
                state_d       = err_d ? IDLE : DONE;
                table_valid_d = ~err_d;
            end else begin
                addr_cnt_d = addr_cnt_q + ADDR_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_cnt_q    <= '0;
            entry_cnt_q   <= '0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            bram_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_cnt_q    <= addr_cnt_d;
            entry_cnt_q   <= entry_cnt_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            bram_en_q     <= bram_en_d;
            busy_q        <= busy_d;
            table_valid_q <= table_valid_d;
        end
    end

    assign o_Cfg_Ready   = (state_q == LOAD);
    assign o_BRAM_Addr   = bram_addr_q;
    assign o_BRAM_Din    = bram_din_q;
    assign o_BRAM_En     = bram_en_q;
    assign o_BRAM_WrEn   = bram_en_q;
    assign o_Busy        = busy_q;
    assign o_Table_Valid = table_valid_q;
    assign o_Entry_Cnt   = entry_cnt_q;
    assign o_Vec_Valid   = i_Vec_Valid & table_valid_q;
    assign o_Vec_Ready   = i_Vec_Read & table_valid_q;
endmodule

// File: tb/tb_thr_table_loader.sv
// Self-checking bench for thr_table_loader with VECTOR_WIDTH=7 (8-entry table).
module tb_thr_table_loader;
    localparam int VW    = 7;
    localparam int CW    = 3;
    localparam int DEPTH = VW + 1;
`ifdef THR_MONO_CHECK_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, i_Start, i_Cfg_Valid, i_Vec_Valid, i_Vec_Read;
    logic [CW-1:0] i_Cfg_Data;
    logic          o_Cfg_Ready, o_BRAM_En, o_BRAM_WrEn, o_Busy, o_Table_Valid, o_Cfg_Err;
    logic          o_Vec_Valid, o_Vec_Ready;
    logic [CW-1:0] o_BRAM_Addr, o_BRAM_Din;
    logic [CW:0]   o_Entry_Cnt;

    int n_pass = 0;
    int n_total = 0;
    bit tv_exp = 1'b0;

    always #5 clk = ~clk;

    thr_table_loader #(.VECTOR_WIDTH(VW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .i_Start(i_Start),
        .i_Cfg_Data(i_Cfg_Data), .i_Cfg_Valid(i_Cfg_Valid), .o_Cfg_Ready(o_Cfg_Ready),
        .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din), .o_BRAM_En(o_BRAM_En),
        .o_BRAM_WrEn(o_BRAM_WrEn), .o_Busy(o_Busy), .o_Table_Valid(o_Table_Valid),
        .o_Entry_Cnt(o_Entry_Cnt), .o_Cfg_Err(o_Cfg_Err),
        .i_Vec_Valid(i_Vec_Valid), .o_Vec_Valid(o_Vec_Valid),
        .i_Vec_Read(i_Vec_Read), .o_Vec_Ready(o_Vec_Ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Randomize vector inputs and check gating against the model's table-valid flag.
    task automatic check_gating(input string tag);
        i_Vec_Valid = 1'($urandom);
        i_Vec_Read  = 1'($urandom);
        #1;
        check({tag, "_vvalid"}, 32'(o_Vec_Valid), 32'(i_Vec_Valid & tv_exp));
        check({tag, "_vready"}, 32'(o_Vec_Ready), 32'(i_Vec_Read & tv_exp));
    endtask

    // Model: entry i lands at address i; a load is rejected only when the check is
    // built and some entry is smaller than its predecessor.
    task automatic run_load(input logic [CW-1:0] ent [DEPTH], input bit gaps);
        int idx = 0;
        int budget = 0;
        bit acc;
        bit err_exp = 1'b0;
        i_Start = 1'b1;
        check_gating("start_cycle");
        tick();
        i_Start = 1'b0;
        tv_exp  = 1'b0;
        check("start_tv", 32'(o_Table_Valid), 32'd0);
        check("start_err", 32'(o_Cfg_Err), 32'd0);
        while (idx < DEPTH && budget < 200) begin
            i_Cfg_Valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_Cfg_Data  = ent[idx];
            check_gating("load");
            check("cfg_ready", 32'(o_Cfg_Ready), 32'd1);
            check("busy", 32'(o_Busy), 32'd1);
            check("entry_cnt", 32'(o_Entry_Cnt), 32'(idx));
            acc = i_Cfg_Valid;
            tick();
            if (acc) begin
                check("wr_en", 32'({o_BRAM_En, o_BRAM_WrEn}), 32'd3);
                check("wr_addr", 32'(o_BRAM_Addr), 32'(idx));
                check("wr_din", 32'(o_BRAM_Din), 32'(ent[idx]));
                if (idx > 0 && ent[idx] < ent[idx-1]) err_exp = 1'b1;
                idx++;
            end else begin
                check("no_wr", 32'({o_BRAM_En, o_BRAM_WrEn}), 32'd0);
            end
            check("cfg_err", 32'(o_Cfg_Err), 32'(MONO && err_exp));
            budget++;
        end
        i_Cfg_Valid = 1'b0;
        if (idx < DEPTH) check("load_timeout", 32'(idx), 32'(DEPTH));
        tv_exp = !(MONO && err_exp);
        check("end_busy", 32'(o_Busy), 32'd0);
        check("end_tv", 32'(o_Table_Valid), 32'(tv_exp));
        check("end_cnt", 32'(o_Entry_Cnt), 32'(DEPTH));
        check("end_ready", 32'(o_Cfg_Ready), 32'd0);
        check_gating("end");
    endtask

    function automatic void rand_table(output logic [CW-1:0] t [DEPTH]);
        int v = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v < (1 << CW) - 1 && $urandom_range(0, 2) == 0) v++;
            t[i] = CW'(v);
        end
    endfunction

    logic [CW-1:0] tbl [DEPTH];

    initial begin
        rst = 1'b1; i_Start = 1'b0; i_Cfg_Valid = 1'b0; i_Cfg_Data = '0;
        i_Vec_Valid = 1'b1; i_Vec_Read = 1'b1;
        tick(); tick();
        check("rst_outs", 32'({o_Cfg_Ready, o_BRAM_En, o_BRAM_WrEn, o_Busy, o_Table_Valid,
                               o_Cfg_Err, o_Vec_Valid, o_Vec_Ready}), 32'd0);
        check("rst_addr_din_cnt", 32'({o_BRAM_Addr, o_BRAM_Din, o_Entry_Cnt}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_not_busy", 32'(o_Busy), 32'd0);

        // Back-to-back load of the reference table.
        tbl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5};
        run_load(tbl, 1'b0);

        // Config traffic outside LOAD is neither acknowledged nor written.
        i_Cfg_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("idle_ready", 32'(o_Cfg_Ready), 32'd0);
            tick();
            check("idle_no_wr", 32'(o_BRAM_En), 32'd0);
            check("done_tv_hold", 32'(o_Table_Valid), 32'd1);
        end
        i_Cfg_Valid = 1'b0;

        // Reload from DONE with random backpressure gaps and random vector traffic.
        rand_table(tbl);
        run_load(tbl, 1'b1);

        // Reset after three entries; rst and i_Start together, reset wins.
        i_Start = 1'b1; tick(); i_Start = 1'b0; tv_exp = 1'b0;
        i_Cfg_Valid = 1'b1; i_Cfg_Data = 3'd6;
        tick(); tick(); tick();
        check("pre_rst_cnt", 32'(o_Entry_Cnt), 32'd3);
        rst = 1'b1; i_Start = 1'b1;
        tick();
        rst = 1'b0; i_Start = 1'b0;
        check("midrst_outs", 32'({o_Cfg_Ready, o_BRAM_En, o_Busy, o_Table_Valid, o_Cfg_Err}), 32'd0);
        check("midrst_cnt", 32'(o_Entry_Cnt), 32'd0);
        tick();
        check("post_rst_no_wr", 32'({o_BRAM_En, o_Busy, o_Cfg_Ready}), 32'd0);
        i_Cfg_Valid = 1'b0;
        rand_table(tbl);
        run_load(tbl, 1'b1);

        // Non-monotonic table: rejected only when the check is built.
        tbl = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        run_load(tbl, 1'b0);
        tick();
        check("post_mono_tv", 32'(o_Table_Valid), 32'(!MONO));

        // A fresh load from wherever that left us still completes.
        rand_table(tbl);
        run_load(tbl, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
